// File: rtl/tmem_bank_loader_if.sv
// rtl/tmem_bank_loader_if.sv - host write bus and TMEM bank write port of the loader
interface tmem_bank_loader_if #(
    parameter int WB_WIDTH  = 32,
    parameter int BANK_BITS = 2
);
    logic [WB_WIDTH-1:0]  DAT_I;
    logic [1:0]           TGA_I;
    logic                 STB_I;
    logic                 CYC_I;
    logic                 WE_I;
    logic                 ACK_O;
    logic [WB_WIDTH-1:0]  TMDAT_O;
    logic [WB_WIDTH-1:0]  TMADR_O;
    logic [BANK_BITS-1:0] TMSEL_O;
    logic                 TMWE_O;
    logic                 BUSY_O;
    logic                 DONE_O;

    // Host side: drives the write request, observes ack and the bank port.
    modport master (
        output DAT_I, TGA_I, STB_I, CYC_I, WE_I,
        input  ACK_O, TMDAT_O, TMADR_O, TMSEL_O, TMWE_O, BUSY_O, DONE_O
    );

    // Loader side.
    modport slave (
        input  DAT_I, TGA_I, STB_I, CYC_I, WE_I,
        output ACK_O, TMDAT_O, TMADR_O, TMSEL_O, TMWE_O, BUSY_O, DONE_O
    );
endinterface

// File: rtl/tmem_bank_loader.sv
// rtl/tmem_bank_loader.sv - linear write stream to interleaved TMEM bank writes
module tmem_bank_loader #(
    parameter int WB_WIDTH   = 32,
    parameter int BANK_BITS  = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic               CLK_I,
    input logic               RST_I,
    tmem_bank_loader_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] TGA_DATA  = 2'b00;
    localparam logic [1:0] TGA_BASE  = 2'b01;
    localparam logic [1:0] TGA_COUNT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_ack;
    logic                  r_done;
    logic                  r_done_pend;
    logic                  r_tmwe;
    logic [WB_WIDTH-1:0]   r_tmdat;
    logic [WB_WIDTH-1:0]   r_tmadr;
    logic [BANK_BITS-1:0]  r_tmsel;

    logic [WB_WIDTH-1:0]   r_base;
    logic [WB_WIDTH-1:0]   r_wvaddr;
    logic [CNT_WIDTH-1:0]  r_rem_in;
    logic [CNT_WIDTH-1:0]  r_rem_out;

    logic [WB_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_fifo_cnt;

    logic                  w_req;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ack_nxt;
    logic                  w_base_ld;
    logic                  w_burst_start;
    logic                  w_zero_done;
    logic                  w_done_nxt;
    logic [CNT_WIDTH-1:0]  w_count;

    // An outstanding ack masks the strobe so a held request is taken only once.
    assign w_req        = bus.STB_I & bus.CYC_I & bus.WE_I & ~r_ack;
    assign w_fifo_full  = (r_fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_pop        = (r_state != S_IDLE) && !w_fifo_empty;
    assign w_count      = bus.DAT_I[CNT_WIDTH-1:0];

    assign bus.ACK_O   = r_ack;
    assign bus.TMWE_O  = r_tmwe;
    assign bus.TMDAT_O = r_tmdat;
    assign bus.TMADR_O = r_tmadr;
    assign bus.TMSEL_O = r_tmsel;
    assign bus.BUSY_O  = (r_state != S_IDLE);
    assign bus.DONE_O  = r_done;

    // State register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command decode: which host writes are accepted in each state, and burst sequencing.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = 1'b0;
        w_base_ld     = 1'b0;
        w_burst_start = 1'b0;
        w_zero_done   = 1'b0;
        w_push        = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && bus.TGA_I == TGA_BASE) begin
                    w_base_ld = 1'b1;
                    w_ack_nxt = 1'b1;
                end else if (w_req && bus.TGA_I == TGA_COUNT) begin
                    w_ack_nxt = 1'b1;
                    if (w_count == '0) begin
                        w_zero_done = 1'b1;
                    end else begin
                        w_burst_start = 1'b1;
                        w_state_nxt   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_req && bus.TGA_I == TGA_DATA && !w_fifo_full && r_rem_in != '0) begin
                    w_push    = 1'b1;
                    w_ack_nxt = 1'b1;
                    if (r_rem_in == CNT_WIDTH'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // remaining_out hits zero on the edge that loads the final bank write.
                if (r_rem_out == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control, counters, FIFO pointers and the registered bank write port.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
            r_tmwe      <= 1'b0;
            r_tmdat     <= '0;
            r_tmadr     <= '0;
            r_tmsel     <= '0;
            r_base      <= '0;
            r_wvaddr    <= '0;
            r_rem_in    <= '0;
            r_rem_out   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            r_ack       <= w_ack_nxt;
            r_done_pend <= w_zero_done;
            r_done      <= w_done_nxt | r_done_pend;

            if (w_base_ld) begin
                r_base <= bus.DAT_I;
            end

            if (w_burst_start) begin
                r_rem_in  <= w_count;
                r_rem_out <= w_count;
                r_wvaddr  <= r_base;
            end else begin
                if (w_push) begin
                    r_rem_in <= r_rem_in - CNT_WIDTH'(1);
                end
                if (w_pop) begin
                    r_rem_out <= r_rem_out - CNT_WIDTH'(1);
                    r_wvaddr  <= r_wvaddr + WB_WIDTH'(1);
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (PTR_W+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (PTR_W+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            // Bank index is the low address bits; the in-bank address is the rest.
            if (w_pop) begin
                r_tmwe  <= 1'b1;
                r_tmdat <= r_fifo[r_rd_ptr];
                r_tmsel <= r_wvaddr[BANK_BITS-1:0];
                r_tmadr <= r_wvaddr >> BANK_BITS;
            end else begin
                r_tmwe  <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are meaningless while the count is zero, so no reset.
    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.DAT_I;
        end
    end
endmodule

// File: tb/tb_tmem_bank_loader.sv
// tb/tb_tmem_bank_loader.sv - scoreboard bench for tmem_bank_loader
module tb_tmem_bank_loader;
    localparam int WB_WIDTH  = 32;
    localparam int BANK_BITS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tmem_bank_loader_if #(.WB_WIDTH(WB_WIDTH), .BANK_BITS(BANK_BITS)) bus ();

    tmem_bank_loader #(
        .WB_WIDTH(WB_WIDTH), .BANK_BITS(BANK_BITS), .CNT_WIDTH(16), .FIFO_DEPTH(4)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BANK_BITS-1:0] sel;
        logic [WB_WIDTH-1:0]  adr;
        logic [WB_WIDTH-1:0]  dat;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  ack_cnt = 0;
    int  done_cnt = 0;
    int  wr_cnt = 0;
    int  last_ack_cyc = -10;
    int  last_wr_cyc = 0;
    int  done_cyc = 0;
    bit  busy_seen = 1'b0;

    function automatic wr_t mk(input logic [WB_WIDTH-1:0] va, input logic [WB_WIDTH-1:0] d);
        wr_t e;
        e.sel = va[BANK_BITS-1:0];
        e.adr = va >> BANK_BITS;
        e.dat = d;
        return e;
    endfunction

    always @(negedge clk) begin
        wr_t got;
        wr_t e;
        cyc++;
        if (bus.BUSY_O) busy_seen = 1'b1;
        if (bus.ACK_O) begin
            ack_cnt++;
            total++;
            if (last_ack_cyc == cyc - 1) begin
                bad++;
                $display("FAIL ack_gap: ack at cycles %0d and %0d, need a gap of 2", last_ack_cyc, cyc);
            end
            last_ack_cyc = cyc;
        end
        if (bus.DONE_O) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.TMWE_O) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            got.sel = bus.TMSEL_O;
            got.adr = bus.TMADR_O;
            got.dat = bus.TMDAT_O;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tm_write_unexpected: got sel=%0d adr=%h dat=%h want none", got.sel, got.adr, got.dat);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL tm_write: got sel=%0d adr=%h dat=%h want sel=%0d adr=%h dat=%h",
                             got.sel, got.adr, got.dat, e.sel, e.adr, e.dat);
                end
            end
        end
    end

    task automatic host_wr(input logic [1:0] tga, input logic [31:0] dat, input int max_cyc,
                           input bit hold, output bit acked);
        acked = 1'b0;
        bus.TGA_I = tga;
        bus.DAT_I = dat;
        bus.STB_I = 1'b1;
        bus.CYC_I = 1'b1;
        bus.WE_I  = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.ACK_O) begin
                acked = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.STB_I = 1'b0;
            bus.CYC_I = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.ACK_O !== 1'b0)  begin bad++; $display("FAIL rst_ack: got %b want 0", bus.ACK_O); end
        total++; if (bus.TMWE_O !== 1'b0) begin bad++; $display("FAIL rst_tmwe: got %b want 0", bus.TMWE_O); end
        total++; if (bus.TMDAT_O !== '0)  begin bad++; $display("FAIL rst_tmdat: got %h want 0", bus.TMDAT_O); end
        total++; if (bus.TMADR_O !== '0)  begin bad++; $display("FAIL rst_tmadr: got %h want 0", bus.TMADR_O); end
        total++; if (bus.TMSEL_O !== '0)  begin bad++; $display("FAIL rst_tmsel: got %0d want 0", bus.TMSEL_O); end
        total++; if (bus.BUSY_O !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.BUSY_O); end
        total++; if (bus.DONE_O !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.DONE_O); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit a;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        host_wr(2'b01, 32'h10, 5, 0, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL basic_base_ack: got %b want 1", a); end
        host_wr(2'b10, 32'd6, 5, 0, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL basic_count_ack: got %b want 1", a); end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(32'h10 + 32'(i), 32'hA0 + 32'(i)));
            host_wr(2'b00, 32'hA0 + 32'(i), 8, 0, a);
            total++; if (a !== 1'b1) begin bad++; $display("FAIL basic_data_ack: word %0d got %b want 1", i, a); end
        end
        repeat (12) @(negedge clk);
        total++; if (wr_cnt - w0 != 6) begin bad++; $display("FAIL basic_writes: got %0d want 6", wr_cnt - w0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
        total++; if (done_cyc - last_wr_cyc != 1) begin bad++; $display("FAIL basic_done_lat: got %0d want 1", done_cyc - last_wr_cyc); end
        total++; if (bus.BUSY_O !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", bus.BUSY_O); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_unaligned();
        bit a;
        int w0 = wr_cnt;
        host_wr(2'b01, 32'h3, 5, 0, a);
        host_wr(2'b10, 32'd2, 5, 0, a);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(32'h3 + 32'(i), 32'hD0 + 32'(i)));
            host_wr(2'b00, 32'hD0 + 32'(i), 8, 0, a);
        end
        repeat (10) @(negedge clk);
        total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL unal_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL unal_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_zero_count();
        bit a;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        busy_seen = 1'b0;
        host_wr(2'b10, 32'd0, 5, 0, a);
        repeat (5) @(negedge clk);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL zero_ack: got %b want 1", a); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done: got %0d want 1", done_cnt - d0); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy_seen); end
        total++; if (wr_cnt - w0 != 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_back_to_back();
        bit a;
        int a0;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        host_wr(2'b01, 32'h100, 5, 0, a);
        host_wr(2'b10, 32'd8, 5, 0, a);
        a0 = ack_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(32'h100 + 32'(i), 32'hB0 + 32'(i)));
            host_wr(2'b00, 32'hB0 + 32'(i), 8, 1, a);
        end
        host_wr(2'b00, 32'hBF, 10, 0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL b2b_ninth_ack: got %b want 0", a); end
        repeat (6) @(negedge clk);
        total++; if (ack_cnt - a0 != 8) begin bad++; $display("FAIL b2b_acks: got %0d want 8", ack_cnt - a0); end
        total++; if (wr_cnt - w0 != 8) begin bad++; $display("FAIL b2b_writes: got %0d want 8", wr_cnt - w0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL b2b_done: got %0d want 1", done_cnt - d0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_illegal();
        bit a;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        host_wr(2'b00, 32'h55, 4, 0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL idle_data_ack: got %b want 0", a); end
        total++; if (bus.BUSY_O !== 1'b0) begin bad++; $display("FAIL idle_data_busy: got %b want 0", bus.BUSY_O); end
        host_wr(2'b01, 32'h20, 5, 0, a);
        host_wr(2'b10, 32'd2, 5, 0, a);
        host_wr(2'b10, 32'd5, 4, 0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL load_count_ack: got %b want 0", a); end
        total++; if (bus.BUSY_O !== 1'b1) begin bad++; $display("FAIL load_count_busy: got %b want 1", bus.BUSY_O); end
        host_wr(2'b01, 32'h99, 4, 0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL load_base_ack: got %b want 0", a); end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(32'h20 + 32'(i), 32'hC8 + 32'(i)));
            host_wr(2'b00, 32'hC8 + 32'(i), 8, 0, a);
        end
        repeat (10) @(negedge clk);
        total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL illegal_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL illegal_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        bit a;
        int w0 = wr_cnt;
        int d0;
        host_wr(2'b01, 32'h40, 5, 0, a);
        host_wr(2'b10, 32'd6, 5, 0, a);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(32'h40 + 32'(i), 32'hC0 + 32'(i)));
            host_wr(2'b00, 32'hC0 + 32'(i), 8, 0, a);
        end
        repeat (4) @(negedge clk);
        total++; if (wr_cnt - w0 != 3) begin bad++; $display("FAIL mid_writes: got %0d want 3", wr_cnt - w0); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.TMDAT_O !== '0)  begin bad++; $display("FAIL mid_rst_tmdat: got %h want 0", bus.TMDAT_O); end
        total++; if (bus.TMADR_O !== '0)  begin bad++; $display("FAIL mid_rst_tmadr: got %h want 0", bus.TMADR_O); end
        total++; if (bus.BUSY_O !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.BUSY_O); end
        total++; if (bus.ACK_O !== 1'b0)  begin bad++; $display("FAIL mid_rst_ack: got %b want 0", bus.ACK_O); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        w0 = wr_cnt;
        d0 = done_cnt;
        host_wr(2'b01, 32'h7, 5, 0, a);
        host_wr(2'b10, 32'd2, 5, 0, a);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(32'h7 + 32'(i), 32'hE0 + 32'(i)));
            host_wr(2'b00, 32'hE0 + 32'(i), 8, 0, a);
        end
        repeat (10) @(negedge clk);
        total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL post_rst_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL post_rst_done: got %0d want 1", done_cnt - d0); end
        total++; if (bus.BUSY_O !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", bus.BUSY_O); end
    endtask

    initial begin
        bus.DAT_I = '0;
        bus.TGA_I = 2'b00;
        bus.STB_I = 1'b0;
        bus.CYC_I = 1'b0;
        bus.WE_I  = 1'b0;
        test_reset();
        test_basic();
        test_unaligned();
        test_zero_count();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_pending: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
